reg_writeback_ctrl: RTL

REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/reg_writeback_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and the write-queue entry layout used by the
// writeback controller and its FIFO.
package wb_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int WB_DEPTH_DEF   = 4;

  // Queue entry at default widths. Modules built with other widths declare
  // the same {rd, data} layout locally and hand it to wb_fifo as a type.
  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write queue for the writeback controller.
//   push/push_entry : enqueue at tail (caller guarantees !full)
//   pop             : dequeue head (caller guarantees !empty)
//   full/empty/count: occupancy
//   head            : entry at read pointer
//   rd_ptr/entries  : raw storage view so the caller can scan for operand hits
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = WB_DEPTH_DEF,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [CW-1:0]           count,
  output logic [PW-1:0]           rd_ptr,
  output entry_t                  head,
  output entry_t [DEPTH-1:0]      entries
);

  entry_t [DEPTH-1:0] mem;
  logic   [PW-1:0]    wr_ptr;

  // Storage is not reset: entry validity comes only from rd_ptr/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges load and ALU results into an in-order write
// queue, drains it to a registered register-file write port, and reports
// pending writes / forwarded data for two decode operands.
//   mem_*/alu_*        : valid/ready write requests (mem has priority)
//   wb_stall           : holds the queue head
//   rf_*               : registered register-file write port
//   chk_regN/pendN/fwd_dataN : combinational pending-write lookup
//   wb_count           : queued entries
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int WB_DEPTH   = WB_DEPTH_DEF,
  localparam int PW        = $clog2(WB_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  wb_stall,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_data_in,
  input  logic [REG_ADDR_W-1:0] chk_reg1,
  input  logic [REG_ADDR_W-1:0] chk_reg2,
  output logic                  pend1,
  output logic                  pend2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2,
  output logic [CW-1:0]         wb_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  logic                    full, empty, push, pop, mem_fire, alu_fire;
  logic [CW-1:0]           count;
  logic [PW-1:0]           rd_ptr;
  entry_t                  push_entry, head;
  entry_t [WB_DEPTH-1:0]   entries;

  // Readies ignore a same-cycle pop: a full queue never accepts.
  assign mem_ready = rst_n & ~full;
  assign alu_ready = rst_n & ~full & ~mem_valid;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;

  // x0 writes finish the handshake but are dropped here.
  always_comb begin
    push       = 1'b0;
    push_entry = '{rd: alu_rd, data: alu_data};
    if (mem_fire) begin
      push       = (mem_rd != '0);
      push_entry = '{rd: mem_rd, data: mem_data};
    end else if (alu_fire) begin
      push       = (alu_rd != '0);
    end
  end

  // empty is registered state, so an entry pushed this edge cannot also pop.
  assign pop = ~empty & ~wb_stall;

  wb_fifo #(.DEPTH(WB_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .head       (head),
    .entries    (entries)
  );

  assign wb_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write <= 1'b0;
      rf_write_reg <= '0;
      rf_data_in   <= '0;
    end else begin
      rf_reg_write <= pop;
      if (pop) begin
        rf_write_reg <= head.rd;
        rf_data_in   <= head.data;
      end
    end
  end

  // Scan oldest to youngest so the last hit wins: output stage first, then
  // queue from head toward tail. Returns {hit, data}.
  function automatic logic [XLEN:0] lookup(input logic [REG_ADDR_W-1:0] chk);
    logic            hit;
    logic [XLEN-1:0] d;
    logic [PW-1:0]   idx;
    hit = 1'b0;
    d   = '0;
    if (rf_reg_write && rf_write_reg == chk) begin
      hit = 1'b1;
      d   = rf_data_in;
    end
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr + k[PW-1:0];
      if (k < int'(count) && entries[idx].rd == chk) begin
        hit = 1'b1;
        d   = entries[idx].data;
      end
    end
    if (chk == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  logic [XLEN:0] look1, look2;
  assign look1     = lookup(chk_reg1);
  assign look2     = lookup(chk_reg2);
  assign pend1     = look1[XLEN];
  assign fwd_data1 = look1[XLEN-1:0];
  assign pend2     = look2[XLEN];
  assign fwd_data2 = look2[XLEN-1:0];

endmodule
